// File: rtl/vx_decode_pkg.sv
// Shared encodings and decoded-instruction layout for the decode queue.
package vx_decode_pkg;

  localparam int EX_BITS       = 3;
  localparam int INST_OP_BITS  = 4;
  localparam int INST_MOD_BITS = 3;
  localparam int NR_BITS       = 5;

  typedef enum logic [EX_BITS-1:0] {
    EX_NOP = 3'd0,
    EX_ALU = 3'd1,
    EX_LSU = 3'd2,
    EX_CSR = 3'd3,
    EX_FPU = 3'd4,
    EX_SFU = 3'd5
  } ex_type_e;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_SYS   = 7'b1110011;
  localparam logic [6:0] OPC_FMADD = 7'b1000011;
  localparam logic [6:0] OPC_EXT   = 7'b0001011;

  // ALU ops below 8 are funct3; loads use {0,funct3}, stores {1,funct3}, SFU funct3
  localparam logic [INST_OP_BITS-1:0] INST_ALU_LUI   = 4'd8;
  localparam logic [INST_OP_BITS-1:0] INST_ALU_AUIPC = 4'd9;
  localparam logic [INST_OP_BITS-1:0] INST_ALU_JAL   = 4'd10;
  localparam logic [INST_OP_BITS-1:0] INST_ALU_JALR  = 4'd11;
  localparam logic [INST_OP_BITS-1:0] INST_FPU_MADD  = 4'd0;

  localparam logic [INST_MOD_BITS-1:0] INST_MOD_NONE = 3'd0;
  localparam logic [INST_MOD_BITS-1:0] INST_MOD_BR   = 3'd1;
  localparam logic [INST_MOD_BITS-1:0] INST_MOD_ALT  = 3'd2;

  typedef struct packed {
    ex_type_e                 ex_type;
    logic [INST_OP_BITS-1:0]  op_type;
    logic [INST_MOD_BITS-1:0] op_mod;
    logic                     wb;
    logic                     use_PC;
    logic                     use_imm;
    logic [31:0]              imm;
    logic [NR_BITS-1:0]       rd;
    logic [NR_BITS-1:0]       rs1;
    logic [NR_BITS-1:0]       rs2;
    logic [NR_BITS-1:0]       rs3;
  } dec_fields_t;

  // Scheduler flags sit outside the stored fields: they are consumed at push time only.
  typedef struct packed {
    dec_fields_t f;
    logic        is_wstall;
    logic        is_join;
  } decoded_t;

endpackage

// File: rtl/vx_decode_core.sv
// Combinational RV32I + Vortex warp-control decoder; illegal opcodes decode to all-zero (EX_NOP).
module vx_decode_core
  import vx_decode_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [NR_BITS-1:0] rd, rs1, rs2, rs3;
  logic [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rs3    = instr[31:27];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec.f.ex_type = EX_ALU;
        dec.f.op_type = (opcode == OPC_LUI) ? INST_ALU_LUI : INST_ALU_AUIPC;
        dec.f.use_PC  = (opcode == OPC_AUIPC);
        dec.f.use_imm = 1'b1;
        dec.f.imm     = imm_u;
        dec.f.rd      = rd;
        dec.f.wb      = (rd != '0);
      end
      OPC_JAL, OPC_JALR: begin
        dec.f.ex_type = EX_ALU;
        dec.f.op_type = (opcode == OPC_JAL) ? INST_ALU_JAL : INST_ALU_JALR;
        dec.f.use_PC  = (opcode == OPC_JAL);
        dec.f.use_imm = 1'b1;
        dec.f.imm     = (opcode == OPC_JAL) ? imm_j : imm_i;
        dec.f.rs1     = (opcode == OPC_JALR) ? rs1 : '0;
        dec.f.rd      = rd;
        dec.f.wb      = (rd != '0);
        dec.is_wstall = 1'b1;
      end
      OPC_BR: begin
        dec.f.ex_type = EX_ALU;
        dec.f.op_type = {1'b0, funct3};
        dec.f.op_mod  = INST_MOD_BR;
        dec.f.use_PC  = 1'b1;
        dec.f.use_imm = 1'b1;
        dec.f.imm     = imm_b;
        dec.f.rs1     = rs1;
        dec.f.rs2     = rs2;
        dec.is_wstall = 1'b1;
      end
      OPC_LOAD, OPC_STORE: begin
        dec.f.ex_type = EX_LSU;
        dec.f.op_type = {(opcode == OPC_STORE), funct3};
        dec.f.use_imm = 1'b1;
        dec.f.imm     = (opcode == OPC_LOAD) ? imm_i : imm_s;
        dec.f.rs1     = rs1;
        dec.f.rs2     = (opcode == OPC_STORE) ? rs2 : '0;
        dec.f.rd      = (opcode == OPC_LOAD) ? rd : '0;
        dec.f.wb      = (opcode == OPC_LOAD) && (rd != '0);
      end
      OPC_OPIMM, OPC_OP: begin
        dec.f.ex_type = EX_ALU;
        dec.f.op_type = {1'b0, funct3};
        // OP uses bit 30 for sub/sra; OP_IMM only for srai, where it is not part of the immediate
        dec.f.op_mod  = (instr[30] && (opcode == OPC_OP || funct3 == 3'b101)) ? INST_MOD_ALT : INST_MOD_NONE;
        dec.f.use_imm = (opcode == OPC_OPIMM);
        dec.f.imm     = (opcode == OPC_OPIMM) ? imm_i : '0;
        dec.f.rs1     = rs1;
        dec.f.rs2     = (opcode == OPC_OP) ? rs2 : '0;
        dec.f.rd      = rd;
        dec.f.wb      = (rd != '0);
      end
      OPC_SYS: begin
        dec.f.ex_type = EX_CSR;
        dec.f.op_type = {1'b0, funct3};
        dec.f.use_imm = 1'b1;
        dec.f.imm     = imm_i;
        dec.f.rs1     = rs1;
        dec.f.rd      = rd;
        dec.f.wb      = (rd != '0);
      end
      OPC_FMADD: begin
        dec.f.ex_type = EX_FPU;
        dec.f.op_type = INST_FPU_MADD;
        dec.f.op_mod  = funct3;
        dec.f.rs1     = rs1;
        dec.f.rs2     = rs2;
        dec.f.rs3     = rs3;
        dec.f.rd      = rd;
        dec.f.wb      = 1'b1;
      end
      OPC_EXT: begin
        if (funct3 <= 3'd5) begin
          dec.f.ex_type = EX_SFU;
          dec.f.op_type = {1'b0, funct3};
          dec.f.rs1     = rs1;
          dec.f.rs2     = rs2;
          dec.is_wstall = (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4});
          dec.is_join   = (funct3 == 3'd3);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vx_decode_queue.sv
// Decode stage: decodes fetched words into a DEPTH-entry elastic FIFO with per-warp occupancy
// and one-cycle wstall/join notifications to the scheduler.
module vx_decode_queue
  import vx_decode_pkg::*;
#(
  parameter  int NUM_WARPS   = 4,
  parameter  int NUM_THREADS = 4,
  parameter  int DEPTH       = 4,
  parameter  int UUID_W      = 44,
  localparam int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [UUID_W-1:0]        in_uuid,
  input  logic [WID_W-1:0]         in_wid,
  input  logic [NUM_THREADS-1:0]   in_tmask,
  input  logic [31:0]              in_PC,
  input  logic [31:0]              in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [UUID_W-1:0]        out_uuid,
  output logic [WID_W-1:0]         out_wid,
  output logic [NUM_THREADS-1:0]   out_tmask,
  output logic [31:0]              out_PC,
  output logic [EX_BITS-1:0]       out_ex_type,
  output logic [INST_OP_BITS-1:0]  out_op_type,
  output logic [INST_MOD_BITS-1:0] out_op_mod,
  output logic                     out_wb,
  output logic                     out_use_PC,
  output logic                     out_use_imm,
  output logic [31:0]              out_imm,
  output logic [NR_BITS-1:0]       out_rd,
  output logic [NR_BITS-1:0]       out_rs1,
  output logic [NR_BITS-1:0]       out_rs2,
  output logic [NR_BITS-1:0]       out_rs3,
  output logic                     wstall_valid,
  output logic [WID_W-1:0]         wstall_wid,
  output logic                     join_valid,
  output logic [WID_W-1:0]         join_wid,
  output logic [NUM_WARPS-1:0]     warp_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  decoded_t                dec;
  dec_fields_t             mem_dec  [DEPTH];
  logic [UUID_W-1:0]       mem_uuid [DEPTH];
  logic [WID_W-1:0]        mem_wid  [DEPTH];
  logic [NUM_THREADS-1:0]  mem_tmask[DEPTH];
  logic [31:0]             mem_pc   [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        wcnt     [NUM_WARPS];
  logic                    push, pop, wr_en;
  dec_fields_t             head;

  vx_decode_core core_i (.instr(in_data), .dec(dec));

  // Full FIFO still accepts when the head leaves in the same cycle
  assign in_ready  = (count < CNT_W'(DEPTH)) | out_ready;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_dec[i]   <= '0;
        mem_uuid[i]  <= '0;
        mem_wid[i]   <= '0;
        mem_tmask[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (wr_en) begin
      mem_dec[wr_ptr]   <= dec.f;
      mem_uuid[wr_ptr]  <= in_uuid;
      mem_wid[wr_ptr]   <= in_wid;
      mem_tmask[wr_ptr] <= in_tmask;
      mem_pc[wr_ptr]    <= in_PC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      for (int w = 0; w < NUM_WARPS; w++) wcnt[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++)
        wcnt[w] <= wcnt[w] + CNT_W'(push && (in_wid == WID_W'(w)))
                           - CNT_W'(pop && (out_wid == WID_W'(w)));
    end
  end

  always_comb begin
    warp_pending = '0;
    for (int w = 0; w < NUM_WARPS; w++) warp_pending[w] = (wcnt[w] != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstall_valid <= 1'b0;
      join_valid   <= 1'b0;
      wstall_wid   <= '0;
      join_wid     <= '0;
    end else begin
      wstall_valid <= wr_en & dec.is_wstall;
      join_valid   <= wr_en & dec.is_join;
      if (wr_en) begin
        wstall_wid <= in_wid;
        join_wid   <= in_wid;
      end
    end
  end

  assign head        = mem_dec[rd_ptr];
  assign out_uuid    = mem_uuid[rd_ptr];
  assign out_wid     = mem_wid[rd_ptr];
  assign out_tmask   = mem_tmask[rd_ptr];
  assign out_PC      = mem_pc[rd_ptr];
  assign out_ex_type = head.ex_type;
  assign out_op_type = head.op_type;
  assign out_op_mod  = head.op_mod;
  assign out_wb      = head.wb;
  assign out_use_PC  = head.use_PC;
  assign out_use_imm = head.use_imm;
  assign out_imm     = head.imm;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rs3     = head.rs3;

`ifndef SYNTHESIS
  logic [31:0] cnt_sum;
  always_comb begin
    cnt_sum = '0;
    for (int w = 0; w < NUM_WARPS; w++) cnt_sum = cnt_sum + 32'(wcnt[w]);
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (cnt_sum == 32'(count));
      assert (!pop || flush || wcnt[out_wid] != '0);
    end
  end
`endif

endmodule

// File: tb/tb_vx_decode_queue.sv
// Directed bench: stimulus pushes hand-computed expectations into a scoreboard; a negedge monitor
// pops and compares on every handshake and tracks the expected wstall/join pulses.
module tb_vx_decode_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [43:0] in_uuid, out_uuid;
  logic [1:0]  in_wid, out_wid, wstall_wid, join_wid;
  logic [3:0]  in_tmask, out_tmask, warp_pending;
  logic [31:0] in_PC, in_data, out_PC, out_imm;
  logic [2:0]  out_ex_type, out_op_mod;
  logic [3:0]  out_op_type;
  logic        out_wb, out_use_PC, out_use_imm, wstall_valid, join_valid;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_rs3;

  always #5 clk = ~clk;

  vx_decode_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid),
    .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_PC), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_wid(out_wid),
    .out_tmask(out_tmask), .out_PC(out_PC), .out_ex_type(out_ex_type), .out_op_type(out_op_type),
    .out_op_mod(out_op_mod), .out_wb(out_wb), .out_use_PC(out_use_PC), .out_use_imm(out_use_imm),
    .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .wstall_valid(wstall_valid), .wstall_wid(wstall_wid), .join_valid(join_valid),
    .join_wid(join_wid), .warp_pending(warp_pending)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  ex;
    logic [3:0]  op;
    logic [2:0]  md;
    logic        wb, upc, uimm;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2, rs3;
    logic        ws, jn;
  } vec_t;

  typedef struct packed {
    logic [43:0] uuid;
    logic [1:0]  wid;
    logic [3:0]  tmask;
    logic [31:0] pc;
    vec_t        v;
  } rec_t;

  vec_t vt [8];
  vec_t cur;
  rec_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic       pend_w = 1'b0, pend_j = 1'b0;
  logic [1:0] pend_wid = '0;

  initial begin
    //          instr          ex   op    md   wb   upc  uimm imm            rd   rs1  rs2  rs3  ws   jn
    vt[0] = '{32'h00510093, 3'd1, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5,        5'd1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0}; // addi x1,x2,5
    vt[1] = '{32'h0000006F, 3'd1, 4'd10,3'd0, 1'b0, 1'b1, 1'b1, 32'd0,        5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0}; // jal x0,0
    vt[2] = '{32'hFFFFFFFF, 3'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0,        5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0}; // illegal
    vt[3] = '{32'h405201B3, 3'd1, 4'd0, 3'd2, 1'b1, 1'b0, 1'b0, 32'd0,        5'd3, 5'd4, 5'd5, 5'd0, 1'b0, 1'b0}; // sub x3,x4,x5
    vt[4] = '{32'h0000B00B, 3'd5, 4'd3, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0,        5'd0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1}; // join x1
    vt[5] = '{32'h0001000B, 3'd5, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0,        5'd0, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0}; // tmc x2
    vt[6] = '{32'hFFC3A303, 3'd2, 4'd2, 3'd0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd6, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0}; // lw x6,-4(x7)
    vt[7] = '{32'h00208463, 3'd1, 4'd0, 3'd1, 1'b0, 1'b1, 1'b1, 32'd8,        5'd0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0}; // beq x1,x2,+8
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int vi, input logic [1:0] wid, input logic [43:0] uuid);
    cur      = vt[vi];
    in_data  = vt[vi].instr;
    in_wid   = wid;
    in_uuid  = uuid;
    in_tmask = 4'b0001 << wid;
    in_PC    = 32'h8000_0000 | {uuid[29:0], 2'b00};
    in_valid = 1'b1;
  endtask

  // Monitor: pulse check, scoreboard pop on handshake, then record this cycle's push
  always @(negedge clk) begin : mon
    rec_t r;
    if (reset) begin
      sb.delete();
      pend_w = 1'b0;
      pend_j = 1'b0;
    end else begin
      check("wstall_valid", 64'(wstall_valid), 64'(pend_w));
      if (pend_w) check("wstall_wid", 64'(wstall_wid), 64'(pend_wid));
      check("join_valid", 64'(join_valid), 64'(pend_j));
      if (pend_j) check("join_wid", 64'(join_wid), 64'(pend_wid));
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) check("unexpected_pop", 64'(out_uuid), 64'hDEAD);
        else begin
          r = sb.pop_front();
          check("uuid",    64'(out_uuid),    64'(r.uuid));
          check("wid",     64'(out_wid),     64'(r.wid));
          check("tmask",   64'(out_tmask),   64'(r.tmask));
          check("PC",      64'(out_PC),      64'(r.pc));
          check("ex_type", 64'(out_ex_type), 64'(r.v.ex));
          check("op_type", 64'(out_op_type), 64'(r.v.op));
          check("op_mod",  64'(out_op_mod),  64'(r.v.md));
          check("wb",      64'(out_wb),      64'(r.v.wb));
          check("use_PC",  64'(out_use_PC),  64'(r.v.upc));
          check("use_imm", 64'(out_use_imm), 64'(r.v.uimm));
          check("imm",     64'(out_imm),     64'(r.v.imm));
          check("rd",      64'(out_rd),      64'(r.v.rd));
          check("rs1",     64'(out_rs1),     64'(r.v.rs1));
          check("rs2",     64'(out_rs2),     64'(r.v.rs2));
          check("rs3",     64'(out_rs3),     64'(r.v.rs3));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{in_uuid, in_wid, in_tmask, in_PC, cur});
      pend_w   = in_valid && in_ready && !flush && cur.ws;
      pend_j   = in_valid && in_ready && !flush && cur.jn;
      pend_wid = in_wid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_uuid = '0; in_wid = '0; in_tmask = '0; in_PC = '0; in_data = '0;
    cur = '0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pending",   64'(warp_pending), 64'd0);
    check("rst_wstall",    64'(wstall_valid), 64'd0);
    check("rst_join",      64'(join_valid), 64'd0);
    check("rst_imm",       64'(out_imm), 64'd0);
    step; step;
    reset = 1'b0;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // addi on warp 2, observed directly while held at the head
    drv(0, 2'd2, 44'd0);
    step;
    in_valid = 1'b0;
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_rd",        64'(out_rd), 64'd1);
    check("t1_rs1",       64'(out_rs1), 64'd2);
    check("t1_imm",       64'(out_imm), 64'd5);
    check("t1_use_imm",   64'(out_use_imm), 64'd1);
    check("t1_wb",        64'(out_wb), 64'd1);
    check("t1_pending",   64'(warp_pending), 64'b0100);
    check("t1_no_wstall", 64'(wstall_valid), 64'd0);
    check("t1_no_join",   64'(join_valid), 64'd0);
    out_ready = 1'b1;
    step;

    // jal x0,0 on warp 1: one-cycle wstall
    drv(1, 2'd1, 44'd1);
    step;
    in_valid = 1'b0;
    check("t2_wstall",     64'(wstall_valid), 64'd1);
    check("t2_wstall_wid", 64'(wstall_wid), 64'd1);
    check("t2_use_PC",     64'(out_use_PC), 64'd1);
    check("t2_wb",         64'(out_wb), 64'd0);
    step;
    check("t2_wstall_drop", 64'(wstall_valid), 64'd0);

    // fill to DEPTH, then push+pop in one cycle while full
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drv(0, 2'(k), 44'(100 + k));
      step;
    end
    drv(0, 2'd0, 44'd104);
    check("t3_full_in_ready", 64'(in_ready), 64'd0);
    check("t3_pending_all",   64'(warp_pending), 64'hF);
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("t3_still_full", 64'(in_ready), 64'd0);
    check("t3_pending",    64'(warp_pending), 64'hF);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) step;
    check("t3_drained", 64'(out_valid), 64'd0);

    // illegal opcode is queued as NOP without pulses
    drv(2, 2'd3, 44'd200);
    step;
    in_valid = 1'b0;
    check("t4_out_valid", 64'(out_valid), 64'd1);
    check("t4_ex_nop",    64'(out_ex_type), 64'd0);
    check("t4_wb",        64'(out_wb), 64'd0);
    check("t4_no_wstall", 64'(wstall_valid), 64'd0);
    check("t4_no_join",   64'(join_valid), 64'd0);
    step;

    // three buffered entries, then flush with a wstall-producing push
    out_ready = 1'b0;
    drv(3, 2'd0, 44'd300); step;
    drv(6, 2'd1, 44'd301); step;
    drv(7, 2'd2, 44'd302); step;
    check("t5_pending_pre", 64'(warp_pending), 64'b0111);
    drv(5, 2'd3, 44'd303);
    flush = 1'b1;
    check("t5_in_ready_flush", 64'(in_ready), 64'd1);
    step;
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_pending",   64'(warp_pending), 64'd0);
    check("t5_no_wstall", 64'(wstall_valid), 64'd0);
    step;

    // async reset mid-cycle with two entries and a live join pulse
    drv(3, 2'd2, 44'd400); step;
    drv(4, 2'd1, 44'd401); step;
    in_valid = 1'b0;
    check("t6_join",     64'(join_valid), 64'd1);
    check("t6_join_wid", 64'(join_wid), 64'd1);
    check("t6_pending",  64'(warp_pending), 64'b0110);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid",   64'(out_valid), 64'd0);
    check("t6_rst_pending", 64'(warp_pending), 64'd0);
    check("t6_rst_join",    64'(join_valid), 64'd0);
    step; step;
    reset = 1'b0;
    check("t6_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    drv(6, 2'd2, 44'hABC_DEF0_1234);
    step;
    in_valid = 1'b0;
    check("t6_first_valid", 64'(out_valid), 64'd1);
    check("t6_first_uuid",  64'(out_uuid), 64'hABC_DEF0_1234);
    check("t6_first_imm",   64'(out_imm), 64'hFFFFFFFC);
    repeat (3) step;
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_decode_queue.md
Name: vx_decode_queue

Overview:
- Decode stage sitting between ifetch response and ibuffer.
- Accepts one fetched instruction per cycle over a valid/ready handshake and decodes it through a combinational core.
- Stores the decoded result in a DEPTH-entry elastic FIFO and tracks per-warp occupancy.
- Emits one-cycle wstall/join notifications toward the warp scheduler.
- Generalises the fixed single-shot decode into a buffered, back-pressured, multi-warp stage.

Parameters:
- NUM_WARPS, 4, number of warps; WID_W = max(1, $clog2(NUM_WARPS)).
- NUM_THREADS, 4, width of the thread mask.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- UUID_W, 44, instruction uuid width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch response valid.
- in_ready  out  1  stage can accept.
- in_uuid  in  UUID_W  instruction uuid.
- in_wid  in  WID_W  warp id.
- in_tmask  in  NUM_THREADS  thread mask.
- in_PC  in  32  instruction PC.
- in_data  in  32  instruction word.
- flush  in  1  drop all buffered entries.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_uuid, out_wid, out_tmask, out_PC  out  as inputs  carried fields.
- out_ex_type  out  EX_BITS  execution unit.
- out_op_type  out  INST_OP_BITS  operation.
- out_op_mod  out  INST_MOD_BITS  modifier.
- out_wb  out  1  writes rd.
- out_use_PC  out  1  PC operand.
- out_use_imm  out  1  imm operand.
- out_imm  out  32  sign-extended immediate.
- out_rd, out_rs1, out_rs2, out_rs3  out  NR_BITS  register indices.
- wstall_valid  out  1  pulse: warp must stall.
- wstall_wid  out  WID_W  warp for wstall.
- join_valid  out  1  pulse: join instruction decoded.
- join_wid  out  WID_W  warp for join.
- warp_pending  out  NUM_WARPS  bit w set when warp w has ≥1 buffered entry.

Behaviour:
- Reset (asynchronous, active-high): FIFO empty, pointers 0, count 0, per-warp counters 0. out_valid=0, wstall_valid=0, join_valid=0, warp_pending=0. in_ready=1 once reset deasserts. Data outputs 0.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count < DEPTH) | out_ready. A full FIFO with simultaneous pop accepts the push; count is unchanged.
- Latency: an instruction pushed in cycle N is at the head, with out_valid=1, in cycle N+1 at the earliest. No combinational in→out path.
- out_valid = (count != 0). Head outputs are stable while out_valid & !out_ready.
- Decode is combinational on in_data at push time. The stored entry holds the decoded fields plus uuid/wid/tmask/PC.
- Illegal opcode: ex_type = EX_NOP, wb=0, all register indices 0. It is still queued.
- wstall_valid: registered, high the cycle after a push whose decode has is_wstall (branch, jal, jalr, tmc/split/bar/wspawn). wstall_wid = pushed wid.
- join_valid: same timing, set by is_join.
- Both pulses may fire in the same cycle. Neither fires on an illegal opcode.
- Per-warp counter width: $clog2(DEPTH+1). Push increments the counter of in_wid; pop decrements that of out_wid. Same warp on push and pop: no change.
- warp_pending[w] = (cnt[w] != 0).
- Pointer wrap: modulo DEPTH through natural overflow of $clog2(DEPTH)-bit pointers.
- flush (synchronous, priority over push and pop):
  - Next cycle: count=0, all per-warp counters=0, out_valid=0.
  - A push in the flush cycle is discarded.
  - wstall/join pulses from the flush-cycle push are suppressed.
  - in_ready is unaffected by flush.
- Reset asserted mid-transfer: all state clears immediately and all pulses drop.
- Assertions, simulation only: the per-warp counter sum equals count; no counter underflow.

Decomposition:
- Package vx_decode_pkg holds EX_BITS, INST_OP_BITS, INST_MOD_BITS, NR_BITS, the EX_* and INST_* encodings, and a packed struct decoded_t (all decoded fields plus is_wstall and is_join).
- Sub-module vx_decode_core: purely combinational, 32-bit word → decoded_t.
- Top level: FIFO storage of decoded_t plus carried fields, counters, pulse registers.

Test Plan:
- Reset, push 0x00510093 (addi x1,x2,5) with wid=2 → next cycle: out_valid=1, rd=1, rs1=2, imm=5, use_imm=1, wb=1, warp_pending=4'b0100, no pulses.
- Push 0x0000006F (jal x0,0) with wid=1 → next cycle: wstall_valid=1, wstall_wid=1 for exactly one cycle; out_use_PC=1, wb=0.
- out_ready=0 and DEPTH+1 back-to-back pushes → in_ready drops after 4 accepts. Then out_ready=1 with in_valid held → push and pop in the same cycle, count stays 4, order preserved by uuid 0..4.
- Push 0xFFFFFFFF (illegal) → queued with ex_type=EX_NOP, wb=0; no pulses.
- Three entries buffered, then flush with a simultaneous push → next cycle: out_valid=0, warp_pending=0, no pulse from the flushed push.
- Reset asserted asynchronously mid-cycle with 2 entries buffered → out_valid and warp_pending go 0 immediately. After release, the first push appears with correct fields.
